// File: rtl/ts_sync_align_if.sv
// ts_sync_align_if: raw TS byte input plus aligned, flagged byte output and lock status
interface ts_sync_align_if;
  logic [7:0] ts_byte;
  logic ts_byte_en;
  logic [8:0] ts_dout;
  logic ts_dout_en;
  logic sync_locked;
  logic [15:0] sync_err_cnt;
  modport master (output ts_byte, ts_byte_en, input ts_dout, ts_dout_en, sync_locked, sync_err_cnt);
  modport slave (input ts_byte, ts_byte_en, output ts_dout, ts_dout_en, sync_locked, sync_err_cnt);
endinterface

// File: rtl/ts_sync_align.sv
// ts_sync_align: hunts for the 0x47 sync byte, locks after LOCK_N hits and emits bytes with a packet-start flag
module ts_sync_align #(
  parameter int PKT_LEN = 188,
  parameter int LOCK_N = 3,
  parameter int UNLOCK_N = 3
) (
  input logic clk_main,
  input logic rst,
  ts_sync_align_if.slave bus
);
  localparam int PW = PKT_LEN > 1 ? $clog2(PKT_LEN) : 1;
  localparam int MX = LOCK_N > UNLOCK_N ? LOCK_N : UNLOCK_N;
  localparam int CW = $clog2(MX + 1);
  typedef enum logic [1:0] {HUNT, VERIFY, LOCKED} state_t;
  state_t state, state_n;
  logic [PW-1:0] pos, pos_n, pos_inc;
  logic [CW-1:0] good, good_n, good_inc, miss, miss_n, miss_inc;
  logic [15:0] err, err_n;
  logic [8:0] dout, dout_n;
  logic dout_en, dout_en_n, is_sync, at_sync, lock_hit, unlock_hit;
  assign is_sync = bus.ts_byte == 8'h47;
  assign at_sync = pos == '0;
  assign pos_inc = (pos == PW'(PKT_LEN - 1)) ? '0 : pos + 1'b1;
  assign good_inc = good + 1'b1;
  assign miss_inc = miss + 1'b1;
  assign lock_hit = is_sync && good_inc == CW'(LOCK_N);
  assign unlock_hit = !is_sync && miss_inc == CW'(UNLOCK_N);
  always_comb begin
    state_n = state;
    pos_n = pos;
    good_n = good;
    miss_n = miss;
    err_n = err;
    dout_n = dout;
    dout_en_n = 1'b0;
    if (bus.ts_byte_en)
      case (state)
        HUNT: if (is_sync) begin
          pos_n = pos_inc;
          good_n = CW'(1);
          state_n = LOCK_N == 1 ? LOCKED : VERIFY;
          dout_en_n = LOCK_N == 1;
          dout_n = LOCK_N == 1 ? 9'h147 : dout;
        end
        VERIFY: begin
          pos_n = pos_inc;
          if (at_sync) begin
            pos_n = is_sync ? pos_inc : '0;
            good_n = is_sync ? good_inc : '0;
            state_n = !is_sync ? HUNT : lock_hit ? LOCKED : VERIFY;
            dout_en_n = lock_hit;
            dout_n = lock_hit ? 9'h147 : dout;
          end
        end
        LOCKED: begin
          pos_n = pos_inc;
          dout_en_n = 1'b1;
          dout_n = {at_sync, bus.ts_byte};
          if (at_sync) begin
            miss_n = is_sync ? '0 : miss_inc;
            err_n = (is_sync || &err) ? err : err + 1'b1;
            // the byte that drops lock is swallowed and hunting restarts on the next byte
            if (unlock_hit) begin
              state_n = HUNT;
              pos_n = '0;
              good_n = '0;
              miss_n = '0;
              dout_en_n = 1'b0;
              dout_n = dout;
            end
          end
        end
        default: state_n = HUNT;
      endcase
  end
  always_ff @(posedge clk_main)
    if (!rst) begin
      state <= HUNT;
      pos <= '0;
      good <= '0;
      miss <= '0;
      err <= '0;
      dout <= '0;
      dout_en <= 1'b0;
    end else begin
      state <= state_n;
      pos <= pos_n;
      good <= good_n;
      miss <= miss_n;
      err <= err_n;
      dout <= dout_n;
      dout_en <= dout_en_n;
    end
  assign bus.ts_dout = dout;
  assign bus.ts_dout_en = dout_en;
  assign bus.sync_locked = state == LOCKED;
  assign bus.sync_err_cnt = err;
endmodule

// File: doc/ts_sync_align.md
TS_SYNC_ALIGN -- requirements
Module: ts_sync_align

Interface
REQ-001 Parameter PKT_LEN, default 188, TS packet length in bytes.
REQ-002 Parameter LOCK_N, default 3, consecutive valid sync bytes needed to lock, including the first one found.
REQ-003 Parameter UNLOCK_N, default 3, consecutive missed sync bytes needed to drop lock.
REQ-004 clk_main  in  1  sole clock; all logic rising-edge.
REQ-005 rst  in  1  reset, synchronous, active-low.
REQ-006 ts_byte  in  8  raw TS byte stream, byte-unaligned.
REQ-007 ts_byte_en  in  1  ts_byte valid this cycle; gaps allowed anywhere.
REQ-008 ts_dout  out  9  bit8 = packet-start flag, bits7:0 = byte; feeds ts_8to64.ts_din.
REQ-009 ts_dout_en  out  1  ts_dout valid; feeds ts_8to64.ts_din_en.
REQ-010 sync_locked  out  1  high while in LOCKED.
REQ-011 sync_err_cnt  out  16  count of missed sync bytes while LOCKED, saturating.

Function
REQ-012 Only cycles with ts_byte_en=1 advance any state or counter; idle cycles hold all state.
REQ-013 FSM states are HUNT, VERIFY and LOCKED; the sync byte is 0x47.
REQ-014 Byte position counter pos runs 0..PKT_LEN-1 and wraps to 0; pos=0 is the expected sync slot.
REQ-015 HUNT: an enabled byte of 0x47 moves the FSM to VERIFY with pos set to 1 and good_cnt=1; all other bytes are discarded.
REQ-016 VERIFY: pos increments per byte; at pos=0, byte 0x47 increments good_cnt; any other byte returns the FSM to HUNT and clears good_cnt.
REQ-017 VERIFY->LOCKED occurs on the sync byte that makes good_cnt=LOCK_N.
REQ-018 That byte is the first output, with bit8=1.
REQ-019 LOCK_N=1 locks directly from HUNT on the first 0x47.
REQ-020 LOCKED: every enabled byte is output; bit8=1 if and only if pos=0.
REQ-021 LOCKED, pos=0, byte≠0x47: the byte is still output with bit8=1 (flywheel), miss_cnt increments and sync_err_cnt increments, saturating at 0xFFFF.
REQ-022 LOCKED, pos=0, byte=0x47: clears miss_cnt.
REQ-023 When miss_cnt reaches UNLOCK_N, the FSM moves to HUNT; that byte is NOT output; the next byte is evaluated as a HUNT byte.
REQ-024 A 0x47 at pos≠0 carries no meaning in any state other than HUNT.
REQ-025 Output latency is exactly 1 clock: ts_dout and ts_dout_en are registered from ts_byte and ts_byte_en.
REQ-026 ts_dout_en=0 in HUNT and VERIFY, and on every non-enabled cycle; ts_dout holds its last value when ts_dout_en=0.
REQ-027 sync_locked is registered and rises in the same cycle as ts_dout_en for the first locked byte.
REQ-028 sync_locked falls 1 clock after the unlocking byte is sampled.
REQ-029 The pos and good/miss counters are sized to ceil(log2(PKT_LEN)) and ceil(log2(max(LOCK_N,UNLOCK_N)+1)) bits.

Reset
REQ-030 When rst=0 at a rising edge, the FSM enters HUNT and pos, good_cnt and miss_cnt are set to 0.
REQ-031 Reset also forces ts_dout=9'h000, ts_dout_en=0, sync_locked=0 and sync_err_cnt=16'h0000.
REQ-032 Reset mid-packet discards the partial packet; no flagged byte is emitted until re-lock.
REQ-033 Reset has priority over ts_byte_en.

Verification
REQ-034 Clean lock: 5 seq'd packets 47 xx..(188B), continuous enable -> no output for packets 1-2; packet 3 byte 0 out as 9'h147 one clk later; sync_locked=1; 3x188=564 bytes out with bit8 set every 188th.
REQ-035 Misalignment: 57 junk bytes then clean packets -> lock starts on 3rd 0x47 at offset 57+376; junk containing an isolated 0x47 sends VERIFY back to HUNT, no output.
REQ-036 Gappy enable: same stream with ts_byte_en toggled 1-0-1 randomly -> output byte sequence identical to the continuous case; ts_dout_en pulses only 1 clk after enabled inputs.
REQ-037 Flywheel/unlock: locked, then corrupt sync of next 2 packets -> both are output with bit8=1 and sync_err_cnt=2, lock stays; corrupt 3 consecutive -> 3rd sync byte is dropped, sync_locked=0 next clk, sync_err_cnt=3.
REQ-038 Miss recovery: miss, good, miss, good... -> miss_cnt never exceeds 1 and lock is held.
REQ-039 Reset mid-packet: rst=0 for 1 clk at byte 100 of locked packet -> all outputs 0 next clk; re-lock needs 3 fresh syncs.
REQ-040 Saturation: sync_err_cnt preloaded via 65535 flywheel misses with UNLOCK_N large -> count sticks at 0xFFFF.
